// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//
// Round-robin arbiter that shares one spi_master among three requesters, one
// per chip select. One requester is granted at a time. The arbiter drives the
// master's start/en/data_in and a one-hot chip-select steer. It tracks
// completion through the master's active-low ss, then returns the received
// byte with a one-cycle acknowledge.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   When defined, a watchdog aborts a transfer after TIMEOUT_CYCLES clocks in
//   WAIT_LOW/WAIT_HIGH. The aborted transfer is reported with err=1 and
//   rsp_data=8'h00. When undefined, the arbiter waits indefinitely and err
//   stays 0.
//
// Parameters:
//   GAP_CYCLES      idle cycles inserted after each completed transaction
//   TIMEOUT_CYCLES  watchdog limit in clocks (timeout build only)
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_req[2:0]          per-requester request; bit i selects chip select i
//   i_req_data[23:0]    TX bytes; requester i uses [8i+7:8i]
//   o_ack[2:0]          one-hot, one-cycle completion pulse
//   o_rsp_data[7:0]     received byte; held until the next ack
//   o_err               timeout flag; valid with ack
//   o_busy              high whenever not idle
//   o_m_start           one-cycle start pulse to the master
//   o_m_en              master enable
//   o_m_data_in[7:0]    TX byte to the master
//   o_m_cs_sel[2:0]     one-hot chip-select steer
//   i_m_ss              master slave-select (active low)
//   i_m_data_out[7:0]   master RX byte

module spi_txn_arbiter #(
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_req,
    input  logic [23:0] i_req_data,
    output logic [2:0]  o_ack,
    output logic [7:0]  o_rsp_data,
    output logic        o_err,
    output logic        o_busy,
    output logic        o_m_start,
    output logic        o_m_en,
    output logic [7:0]  o_m_data_in,
    output logic [2:0]  o_m_cs_sel,
    input  logic        i_m_ss,
    input  logic [7:0]  i_m_data_out
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitLow,
        StWaitHigh,
        StDone,
        StGap
    } state_t;

    state_t      r_state, w_state_d;
    logic [1:0]  r_idx, w_idx_d;
    logic [1:0]  r_last, w_last_d;
    logic [2:0]  r_cs_sel, w_cs_sel_d;
    logic [7:0]  r_data_in, w_data_in_d;
    logic [7:0]  r_rsp, w_rsp_d;
    logic        r_err, w_err_d;
    logic [7:0]  r_gap, w_gap_d;

    // Round-robin search order is last+1, last+2 (== last-1), last, all mod 3.
    logic [1:0]  w_cand1, w_cand2, w_win;
    logic [7:0]  w_win_byte;
    logic        w_to_hit;

    assign w_cand1    = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    assign w_cand2    = (r_last == 2'd0) ? 2'd2 : r_last - 2'd1;
    assign w_win      = i_req[w_cand1] ? w_cand1 :
                        i_req[w_cand2] ? w_cand2 : r_last;
    assign w_win_byte = i_req_data[{w_win, 3'b000} +: 8];

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] r_to_cnt, w_to_cnt_d;

    // The limit is reached on the cycle whose increment would make the count
    // equal TIMEOUT_CYCLES, so a transfer gets exactly TIMEOUT_CYCLES wait cycles.
    assign w_to_hit = ((r_to_cnt + 16'd1) == 16'(TIMEOUT_CYCLES));

    always_comb begin
        w_to_cnt_d = r_to_cnt;
        if (r_state == StStart) begin
            w_to_cnt_d = 16'd0;
        end else if (r_state == StWaitLow || r_state == StWaitHigh) begin
            w_to_cnt_d = r_to_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= 16'd0;
        end else begin
            r_to_cnt <= w_to_cnt_d;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    always_comb begin
        w_state_d   = r_state;
        w_idx_d     = r_idx;
        w_last_d    = r_last;
        w_cs_sel_d  = r_cs_sel;
        w_data_in_d = r_data_in;
        w_rsp_d     = r_rsp;
        w_err_d     = r_err;
        w_gap_d     = r_gap;
        unique case (r_state)
            StIdle: begin
                if (|i_req) begin
                    w_idx_d     = w_win;
                    w_cs_sel_d  = 3'b001 << w_win;
                    w_data_in_d = w_win_byte;
                    w_state_d   = StStart;
                end
            end
            StStart: w_state_d = StWaitLow;
            StWaitLow: begin
                if (!i_m_ss) begin
                    w_state_d = StWaitHigh;
                end else if (w_to_hit) begin
                    w_rsp_d   = 8'h00;
                    w_err_d   = 1'b1;
                    w_state_d = StDone;
                end
            end
            StWaitHigh: begin
                // Completion has priority over a timeout in the same cycle.
                if (i_m_ss) begin
                    w_rsp_d   = i_m_data_out;
                    w_err_d   = 1'b0;
                    w_state_d = StDone;
                end else if (w_to_hit) begin
                    w_rsp_d   = 8'h00;
                    w_err_d   = 1'b1;
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_last_d   = r_idx;
                w_cs_sel_d = 3'b000;
                w_gap_d    = 8'd0;
                w_state_d  = (GAP_CYCLES == 0) ? StIdle : StGap;
            end
            StGap: begin
                if (r_gap == 8'(GAP_CYCLES - 1)) begin
                    w_state_d = StIdle;
                end else begin
                    w_gap_d = r_gap + 8'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_idx     <= 2'd0;
            r_last    <= 2'd2;
            r_cs_sel  <= 3'b000;
            r_data_in <= 8'h00;
            r_rsp     <= 8'h00;
            r_err     <= 1'b0;
            r_gap     <= 8'd0;
        end else begin
            r_state   <= w_state_d;
            r_idx     <= w_idx_d;
            r_last    <= w_last_d;
            r_cs_sel  <= w_cs_sel_d;
            r_data_in <= w_data_in_d;
            r_rsp     <= w_rsp_d;
            r_err     <= w_err_d;
            r_gap     <= w_gap_d;
        end
    end

    // Control outputs decode straight from state so reset clears them at once.
    assign o_m_start   = (r_state == StStart);
    assign o_m_en      = (r_state == StStart) || (r_state == StWaitLow) ||
                         (r_state == StWaitHigh);
    assign o_busy      = (r_state != StIdle);
    assign o_ack       = (r_state == StDone) ? (3'b001 << r_idx) : 3'b000;
    assign o_rsp_data  = r_rsp;
    assign o_err       = r_err;
    assign o_m_data_in = r_data_in;
    assign o_m_cs_sel  = r_cs_sel;

endmodule
